// File: rtl/data_mem_responder.sv
// Data memory responder for the MEM-stage load/store port.
// Accepts one request at a time, holds the pipeline for a fixed latency, then
// returns aligned and extended load data (or commits a byte-lane store) with a
// single-cycle ack. Misaligned or illegal accesses complete with err_o and no
// array access.

module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        start_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic        stall_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
    // Counter only ever holds values up to LATENCY-1.
    localparam int unsigned CntW = (LATENCY < 2) ? 1 : $clog2(LATENCY);
    localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;

    // Request fields captured at acceptance
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [1:0]      size_q;
    logic            unsigned_q;

    logic [31:0]     mem_q [DEPTH_WORDS];

    // Fields of the access being committed. With LATENCY=1 the commit edge is
    // the acceptance edge, so the live inputs are used while idle.
    logic            acc_we;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;
    logic [1:0]      acc_size;
    logic            acc_unsigned;
    logic [IdxW-1:0] acc_idx;
    logic            acc_err;
    logic            commit;

    logic [3:0]      wr_be;
    logic [31:0]     wr_data;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     load_val;

    logic            unused_addr_hi;

    // Select live or latched request fields for the commit datapath
    always_comb begin
        acc_we       = we_q;
        acc_addr     = addr_q;
        acc_wdata    = wdata_q;
        acc_size     = size_q;
        acc_unsigned = unsigned_q;
        if (state_q == StIdle) begin
            acc_we       = we_i;
            acc_addr     = addr_i;
            acc_wdata    = wdata_i;
            acc_size     = size_i;
            acc_unsigned = unsigned_i;
        end
    end

    assign acc_idx = acc_addr[IdxW+1:2];
    // Upper address bits are ignored so accesses wrap around the array.
    assign unused_addr_hi = ^acc_addr[31:IdxW+2];

    // Alignment / size legality check
    always_comb begin
        acc_err = 1'b0;
        unique case (acc_size)
            2'b00:   acc_err = 1'b0;
            2'b01:   acc_err = acc_addr[0];
            2'b10:   acc_err = (acc_addr[1:0] != 2'b00);
            default: acc_err = 1'b1;
        endcase
    end

    // Commit happens on the edge that enters StResp
    assign commit = ((state_q == StIdle) && req_i && (LATENCY == 1)) ||
                    ((state_q == StBusy) && (cnt_q == CntOne));

    // Store byte enables and lane-replicated write data
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = acc_wdata;
        unique case (acc_size)
            2'b00: begin
                wr_be   = 4'b0001 << acc_addr[1:0];
                wr_data = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{acc_wdata[15:0]}};
            end
            2'b10: begin
                wr_be   = 4'b1111;
                wr_data = acc_wdata;
            end
            default: begin
                wr_be   = 4'b0000;
                wr_data = acc_wdata;
            end
        endcase
        if (acc_err) begin
            wr_be = 4'b0000;
        end
    end

    // Load lane selection and sign/zero extension
    always_comb begin
        rd_word = mem_q[acc_idx];
        rd_byte = rd_word[7:0];
        unique case (acc_addr[1:0])
            2'b00: rd_byte = rd_word[7:0];
            2'b01: rd_byte = rd_word[15:8];
            2'b10: rd_byte = rd_word[23:16];
            2'b11: rd_byte = rd_word[31:24];
        endcase
        rd_half  = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        unique case (acc_size)
            2'b00: begin
                load_val = acc_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            2'b01: begin
                load_val = acc_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end
            default: load_val = rd_word;
        endcase
    end

    // Pipeline hold: pending request while idle, or access in flight
    assign stall_o = ((state_q == StIdle) && req_i) || (state_q == StBusy);

    // Control FSM with registered ack/response outputs
    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ack_o      <= 1'b0;
            err_o      <= 1'b0;
            rdata_o    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_i) begin
                        we_q       <= we_i;
                        addr_q     <= addr_i;
                        wdata_q    <= wdata_i;
                        size_q     <= size_i;
                        unsigned_q <= unsigned_i;
                        cnt_q      <= CntInit;
                        if (LATENCY == 1) begin
                            state_q <= StResp;
                            ack_o   <= 1'b1;
                        end else begin
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        state_q <= StResp;
                        ack_o   <= 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
            if (commit) begin
                err_o   <= acc_err;
                rdata_o <= (acc_we || acc_err) ? 32'h0 : load_val;
            end
        end
    end

    // Byte-lane array write at commit; reset blocks any pending store
    always_ff @(posedge clk_i) begin
        if (start_i && commit && acc_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk;
    logic        start_i;
    logic        req0, req1;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic        stall0, ack0, err0;
    logic [31:0] rdata0;
    logic        stall1, ack1, err1;
    logic [31:0] rdata1;

    int n_cmp  = 0;
    int n_fail = 0;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut (
        .clk_i      (clk),
        .start_i    (start_i),
        .req_i      (req0),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .stall_o    (stall0),
        .ack_o      (ack0),
        .rdata_o    (rdata0),
        .err_o      (err0)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
        .clk_i      (clk),
        .start_i    (start_i),
        .req_i      (req1),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .stall_o    (stall1),
        .ack_o      (ack1),
        .rdata_o    (rdata1),
        .err_o      (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request at posedge+1 and wait (bounded) for its ack.
    // lat = edges from request to ack (0 = timed out); stall_cnt counts stall
    // samples that were high, including the request cycle and the ack cycle.
    task automatic access(input bit sel, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                          output int lat, output int stall_cnt,
                          output logic [31:0] rd, output logic er);
        we_i = we; addr_i = addr; wdata_i = wdata; size_i = size; unsigned_i = uns;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        #1;
        stall_cnt = sel ? int'(stall1) : int'(stall0);
        lat = 0;
        rd = 'x;
        er = 1'bx;
        for (int e = 1; e <= 20 && lat == 0; e++) begin
            @(posedge clk); #1;
            stall_cnt += sel ? int'(stall1) : int'(stall0);
            if ((sel ? ack1 : ack0) === 1'b1) begin
                lat = e;
                rd  = sel ? rdata1 : rdata0;
                er  = sel ? err1 : err0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        start_i = 1'b0; req0 = 1'b0; req1 = 1'b0;
        we_i = 1'b0; addr_i = '0; wdata_i = '0; size_i = 2'b10; unsigned_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack0); end
        n_cmp++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err0); end
        n_cmp++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata0); end
        n_cmp++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall0); end
        n_cmp++; if (ack1 !== 1'b0) begin n_fail++; $display("FAIL reset_ack_lat1: got %b want 0", ack1); end
        start_i = 1'b1;
    endtask

    task automatic test_word();
        int lat, sc; logic [31:0] rd; logic er;
        access(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, lat, sc, rd, er);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL st_word_lat: got %0d want 3", lat); end
        n_cmp++; if (sc !== 3) begin n_fail++; $display("FAIL st_word_stall: got %0d want 3", sc); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL st_word_err: got %b want 0", er); end
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL st_word_rdata: got %h want 0", rd); end
        access(0, 0, 32'h10, 32'h0, 2'b10, 0, lat, sc, rd, er);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL ld_word_lat: got %0d want 3", lat); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_word: got %h want deadbeef", rd); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL ld_word_err: got %b want 0", er); end
    endtask

    task automatic test_lanes();
        int lat, sc; logic [31:0] rd; logic er;
        access(0, 1, 32'h11, 32'h00000055, 2'b00, 0, lat, sc, rd, er);
        access(0, 0, 32'h10, 32'h0, 2'b10, 0, lat, sc, rd, er);
        n_cmp++; if (rd !== 32'hDEAD55EF) begin n_fail++; $display("FAIL st_byte_word: got %h want dead55ef", rd); end
        access(0, 0, 32'h13, 32'h0, 2'b00, 0, lat, sc, rd, er);
        n_cmp++; if (rd !== 32'hFFFFFFDE) begin n_fail++; $display("FAIL ld_byte_s: got %h want ffffffde", rd); end
        access(0, 0, 32'h13, 32'h0, 2'b00, 1, lat, sc, rd, er);
        n_cmp++; if (rd !== 32'h000000DE) begin n_fail++; $display("FAIL ld_byte_u: got %h want 000000de", rd); end
        access(0, 0, 32'h11, 32'h0, 2'b00, 0, lat, sc, rd, er);
        n_cmp++; if (rd !== 32'h00000055) begin n_fail++; $display("FAIL ld_byte_pos: got %h want 00000055", rd); end
        access(0, 0, 32'h12, 32'h0, 2'b01, 0, lat, sc, rd, er);
        n_cmp++; if (rd !== 32'hFFFFDEAD) begin n_fail++; $display("FAIL ld_half_s: got %h want ffffdead", rd); end
        access(0, 0, 32'h10, 32'h0, 2'b01, 1, lat, sc, rd, er);
        n_cmp++; if (rd !== 32'h000055EF) begin n_fail++; $display("FAIL ld_half_u: got %h want 000055ef", rd); end
    endtask

    task automatic test_misaligned();
        int lat, sc; logic [31:0] rd; logic er;
        access(0, 1, 32'h12, 32'h11111111, 2'b10, 0, lat, sc, rd, er);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL mis_st_err: got %b want 1", er); end
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mis_st_rdata: got %h want 0", rd); end
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL mis_st_lat: got %0d want 3", lat); end
        access(0, 0, 32'h10, 32'h0, 2'b10, 0, lat, sc, rd, er);
        n_cmp++; if (rd !== 32'hDEAD55EF) begin n_fail++; $display("FAIL mis_unchanged: got %h want dead55ef", rd); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL mis_clear_err: got %b want 0", er); end
        access(0, 0, 32'h10, 32'h0, 2'b11, 0, lat, sc, rd, er);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL size11_err: got %b want 1", er); end
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL size11_rdata: got %h want 0", rd); end
        access(0, 0, 32'h11, 32'h0, 2'b01, 0, lat, sc, rd, er);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL mis_half_err: got %b want 1", er); end
    endtask

    task automatic test_back_to_back();
        int e1, e2, acks; logic [31:0] rd1, rd2; logic st_after;
        e1 = 0; e2 = 0; acks = 0; st_after = 1'b0; rd1 = '0; rd2 = '0;
        we_i = 1'b0; addr_i = 32'h10; size_i = 2'b10; unsigned_i = 1'b0; req0 = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk); #1;
            if (e1 != 0 && e == e1 + 1) st_after = stall0;
            if (ack0 === 1'b1) begin
                acks++;
                if (acks == 1) begin
                    e1 = e; rd1 = rdata0;
                    addr_i = 32'h13; size_i = 2'b00; unsigned_i = 1'b1;
                end else if (acks == 2) begin
                    e2 = e; rd2 = rdata0; req0 = 1'b0;
                end
            end
        end
        req0 = 1'b0;
        n_cmp++; if (e1 !== 3) begin n_fail++; $display("FAIL b2b_first_ack: got %0d want 3", e1); end
        n_cmp++; if (e2 !== 7) begin n_fail++; $display("FAIL b2b_second_ack: got %0d want 7", e2); end
        n_cmp++; if (acks !== 2) begin n_fail++; $display("FAIL b2b_ack_count: got %0d want 2", acks); end
        n_cmp++; if (st_after !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_after_ack: got %b want 1", st_after); end
        n_cmp++; if (rd1 !== 32'hDEAD55EF) begin n_fail++; $display("FAIL b2b_rdata1: got %h want dead55ef", rd1); end
        n_cmp++; if (rd2 !== 32'h000000DE) begin n_fail++; $display("FAIL b2b_rdata2: got %h want 000000de", rd2); end
    endtask

    task automatic test_reset_mid();
        int lat, sc, acks; logic [31:0] rd; logic er;
        access(0, 1, 32'h20, 32'hCAFEF00D, 2'b10, 0, lat, sc, rd, er);
        access(0, 0, 32'h20, 32'h0, 2'b10, 0, lat, sc, rd, er);
        n_cmp++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_mid_setup: got %h want cafef00d", rd); end
        we_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h12345678; size_i = 2'b10; req0 = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; req0 = 1'b0;
        acks = 0;
        @(posedge clk); #1;
        acks += int'(ack0);
        n_cmp++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rdata: got %h want 0", rdata0); end
        n_cmp++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %b want 0", err0); end
        start_i = 1'b1;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            acks += int'(ack0);
        end
        n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL rst_mid_no_ack: got %0d want 0", acks); end
        n_cmp++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b want 0", stall0); end
        access(0, 0, 32'h20, 32'h0, 2'b10, 0, lat, sc, rd, er);
        n_cmp++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_mid_unchanged: got %h want cafef00d", rd); end
    endtask

    task automatic test_lat1_wrap();
        int lat, sc; logic [31:0] rd; logic er;
        access(1, 1, 32'h400, 32'h0BADCAFE, 2'b10, 0, lat, sc, rd, er);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL lat1_st_lat: got %0d want 1", lat); end
        n_cmp++; if (sc !== 1) begin n_fail++; $display("FAIL lat1_stall: got %0d want 1", sc); end
        access(1, 0, 32'h0, 32'h0, 2'b10, 0, lat, sc, rd, er);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL lat1_ld_lat: got %0d want 1", lat); end
        n_cmp++; if (rd !== 32'h0BADCAFE) begin n_fail++; $display("FAIL wrap_word0: got %h want 0badcafe", rd); end
        access(1, 0, 32'h401, 32'h0, 2'b00, 0, lat, sc, rd, er);
        n_cmp++; if (rd !== 32'hFFFFFFCA) begin n_fail++; $display("FAIL wrap_byte: got %h want ffffffca", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        test_lat1_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder to the CPU's MEM-stage load/store initiator.
- Accepts one request at a time and applies a fixed access latency.
- Stalls the pipeline until the access completes.
- Returns aligned, sign- or zero-extended load data for capture as the load-data input of the MEM/WB pipeline register.
- Stores use byte-lane writes into an internal word-organised array.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array (power of 2)
LATENCY, 3, cycles from request acceptance to ack_o (>=1)

Ports:
clk_i  in  1  clock, rising edge
start_i  in  1  synchronous active-low reset
req_i  in  1  access request; CPU holds it and all request fields stable while stall_o=1
we_i  in  1  1=store, 0=load
addr_i  in  32  byte address
wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
size_i  in  2  00=byte, 01=half, 10=word, 11=illegal
unsigned_i  in  1  load zero-extend when 1, sign-extend when 0
stall_o  out  1  pipeline hold
ack_o  out  1  one-cycle completion pulse
rdata_o  out  32  load result
err_o  out  1  misaligned/illegal flag, valid with ack_o

Behaviour:
- One clock. Reset is synchronous and active-low on start_i, sampled at the rising edge of clk_i.
- Reset values:
  - state=IDLE, ack_o=0, err_o=0, rdata_o=0, counter=0.
  - Array contents are not cleared.
- Reset mid-operation:
  - Any in-flight request is dropped.
  - A store that has not reached commit does not modify the array.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If req_i=1 at an edge, latch we/addr/wdata/size/unsigned and load counter=LATENCY-1.
  - Go to RESP if LATENCY=1, else go to BUSY.
- BUSY:
  - Decrement counter each edge.
  - When counter=1 at an edge, go to RESP.
- RESP:
  - ack_o=1 for exactly this one cycle. Return to IDLE at the next edge.
  - req_i is ignored in RESP. The next request is accepted no earlier than the cycle after ack_o.
- Timing: a request sampled at edge T gives ack_o=1 in the cycle following edge T+LATENCY-1, i.e. exactly LATENCY cycles after acceptance.
- stall_o (combinational): 1 when (state=IDLE and req_i=1) or state=BUSY; 0 in RESP and in idle with no request.
- Commit: a store writes the array, and a load reads the array into rdata_o, at the edge entering RESP.
- Addressing:
  - Word index = addr[clog2(DEPTH_WORDS)+1:2].
  - Higher address bits are ignored, so out-of-range addresses wrap.
- Store lanes:
  - byte: lane addr[1:0] gets wdata[7:0].
  - half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0], little-endian.
  - word: all four lanes.
  - Unwritten lanes are preserved.
- Load extraction: select byte/half at addr offset, then extend per unsigned_i to 32 bits.
- Error:
  - Condition: size=11, or half with addr[0]=1, or word with addr[1:0]!=00.
  - Response: no array access; err_o=1 and rdata_o=0 at ack.
  - Latency is unchanged.
- Output hold:
  - rdata_o and err_o hold their values until the next commit.
  - A store ack sets rdata_o=0 and err_o per the check.
- Simultaneous events: start_i=0 overrides any request or commit in the same cycle.

Test Plan:
- Reset then word store/load, LATENCY=3:
  - Store 0xDEADBEEF at 0x10: stall_o high for 3 cycles from req, ack_o pulse in cycle 3, array word 4 = 0xDEADBEEF.
  - Load word 0x10 -> rdata_o=0xDEADBEEF with ack_o, err_o=0.
- Byte/half lanes and extension:
  - After the word above, store byte 0x55 at 0x11 -> word 4 = 0xDEAD55EF.
  - Load byte 0x13 signed -> 0xFFFFFFDE. Load byte 0x13 unsigned -> 0x000000DE.
  - Load half 0x12 signed -> 0xFFFFDEAD.
- Misaligned:
  - Word store at 0x12 -> err_o=1 at ack, rdata_o=0, word 4 unchanged.
  - size=11 load -> err_o=1.
- Back-to-back:
  - req_i held high across ack -> second request accepted the cycle after ack.
  - Second ack exactly 4 cycles after first ack (LATENCY=3).
  - No duplicate ack.
- Reset mid-operation:
  - Assert start_i=0 one cycle after accepting a store of 0x12345678 to 0x20 -> no ack, word 8 unchanged, outputs zero.
  - Idle with stall_o=0 after release.
- Parameter corners:
  - LATENCY=1 -> ack in the cycle after req.
  - Address 0x400 with DEPTH_WORDS=256 wraps to word 0.
